// File: rtl/matrix_pkg.sv
// Shared types and constants for the 5x7 LED matrix scan sequencer.
package matrix_pkg;

    localparam int unsigned COL_W      = 7;
    localparam int unsigned RING_W     = 3;
    localparam int unsigned NUM_PHASES = 3;
    localparam int unsigned PHASE_W    = 2;

    typedef logic [COL_W-1:0]   col_bits_t;
    typedef logic [RING_W-1:0]  ring_t;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam ring_t RING_IDLE = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // One full image: bitmaps for the three column groups.
    typedef struct packed {
        col_bits_t col2;
        col_bits_t col1;
        col_bits_t col0;
    } image_t;

    // One-hot column-phase select for a given phase index.
    function automatic ring_t phase_ring(input phase_t p);
        return ring_t'(3'b001 << p);
    endfunction

endpackage

// File: rtl/matrix_image_buffer.sv
// Pending/active image registers with valid/ready intake and boundary load.
module matrix_image_buffer
    import matrix_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   img_valid,
    output logic   img_ready,
    input  image_t img_in,
    input  logic   load_en,
    output image_t active
);

    image_t pending_q, pending_d;
    image_t active_q, active_d;
    logic   pending_full_q, pending_full_d;

    // Boundary load drains pending first; intake only fills an empty slot.
    always_comb begin
        pending_d      = pending_q;
        active_d       = active_q;
        pending_full_d = pending_full_q;
        if (load_en && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (img_valid && !pending_full_q) begin
            pending_d      = img_in;
            pending_full_d = 1'b1;
        end
    end

    // Image state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            active_q       <= active_d;
            pending_full_q <= pending_full_d;
        end
    end

    assign img_ready = !pending_full_q;
    assign active    = active_q;

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-phase sequencer for the 5x7 LED matrix with blanking and tear-free image swap.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W =
        $clog2(((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) + 1)
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      enable,
    input  logic      img_valid,
    output logic      img_ready,
    input  col_bits_t img_col2,
    input  col_bits_t img_col1,
    input  col_bits_t img_col0,
    output ring_t     ring_counter,
    output col_bits_t col_2,
    output col_bits_t col_1,
    output col_bits_t col_0,
    output logic      frame_done
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam phase_t           PHASE_LAST = PHASE_W'(NUM_PHASES - 1);

    scan_state_t      state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ring_t            ring_q, ring_d;
    logic             frame_done_q, frame_done_d;
    logic             load_c;
    image_t           active;

    // Next-state, counters, and look-ahead of the registered outputs.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            phase_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    load_c  = 1'b1;
                    state_d = BLANK;
                    phase_d = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (phase_q == PHASE_LAST) begin
                            phase_d = '0;
                            load_c  = 1'b1;
                        end else begin
                            phase_d = phase_q + PHASE_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        ring_d       = (state_d == SHOW) ? phase_ring(phase_d) : RING_IDLE;
        frame_done_d = (state_d == SHOW) && (phase_d == PHASE_LAST) && (cnt_d == DWELL_LAST);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            cnt_q        <= '0;
            ring_q       <= RING_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            ring_q       <= ring_d;
            frame_done_q <= frame_done_d;
        end
    end

    matrix_image_buffer u_buf (
        .clock     (clock),
        .reset     (reset),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .img_in    ({img_col2, img_col1, img_col0}),
        .load_en   (load_c),
        .active    (active)
    );

    assign ring_counter = ring_q;
    assign frame_done   = frame_done_q;
    assign col_2        = active.col2;
    assign col_1        = active.col1;
    assign col_0        = active.col0;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller (DWELL=4, BLANK=2).
module tb_matrix_scan_controller;
    import matrix_pkg::*;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SEG   = DW + BL;
    localparam int FRAME = 3 * SEG;

    localparam image_t IMG_NONE = '0;
    localparam image_t IMG_A    = {7'h41, 7'h22, 7'h1C};
    localparam image_t IMG_B    = {7'h7F, 7'h7F, 7'h7F};
    localparam image_t IMG_C    = {7'h15, 7'h2A, 7'h08};
    localparam image_t IMG_D    = {7'h63, 7'h14, 7'h36};

    logic      clock = 1'b0;
    logic      reset;
    logic      enable;
    logic      img_valid;
    logic      img_ready;
    col_bits_t img_col2, img_col1, img_col0;
    ring_t     ring_counter;
    col_bits_t col_2, col_1, col_0;
    logic      frame_done;

    always #5 clock = ~clock;

    matrix_scan_controller #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .img_valid    (img_valid),
        .img_ready    (img_ready),
        .img_col2     (img_col2),
        .img_col1     (img_col1),
        .img_col0     (img_col0),
        .ring_counter (ring_counter),
        .col_2        (col_2),
        .col_1        (col_1),
        .col_0        (col_0),
        .frame_done   (frame_done)
    );

    typedef struct {
        ring_t     ring;
        logic      fd;
        logic      rdy;
        col_bits_t c2;
        col_bits_t c1;
        col_bits_t c0;
    } exp_t;

    typedef struct {
        logic  en;
        logic  vld;
        ring_t ring;
        logic  fd;
    } vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: k counts cycles since the IDLE->BLANK edge (-1 = idle).
    int     m_k;
    logic   m_pf;
    image_t m_pend;
    image_t m_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k    = -1;
        m_pf   = 1'b0;
        m_pend = '0;
        m_act  = '0;
    endtask

    // Drive one cycle, predict its outcome into the scoreboard, then compare.
    task automatic step(input logic en, input logic vld, input image_t img);
        exp_t e;
        logic xfer;
        @(negedge clock);
        enable    = en;
        img_valid = vld;
        {img_col2, img_col1, img_col0} = img;
        xfer = vld && !m_pf;
        if (!en) begin
            m_k = -1;
        end else begin
            if ((m_k < 0 || (m_k % FRAME) == FRAME - 1) && m_pf) begin
                m_act = m_pend;
                m_pf  = 1'b0;
            end
            m_k = (m_k < 0) ? 0 : m_k + 1;
        end
        if (xfer) begin
            m_pend = img;
            m_pf   = 1'b1;
        end
        e.ring = (m_k >= 0 && (m_k % SEG) >= BL) ? ring_t'(1 << ((m_k % FRAME) / SEG)) : 3'b000;
        e.fd   = (m_k >= 0) && ((m_k % FRAME) == FRAME - 1);
        e.rdy  = !m_pf;
        e.c2   = m_act.col2;
        e.c1   = m_act.col1;
        e.c0   = m_act.col0;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk("sb_ring",  32'(ring_counter), 32'(e.ring));
        chk("sb_fd",    32'(frame_done),   32'(e.fd));
        chk("sb_ready", 32'(img_ready),    32'(e.rdy));
        chk("sb_col2",  32'(col_2),        32'(e.c2));
        chk("sb_col1",  32'(col_1),        32'(e.c1));
        chk("sb_col0",  32'(col_0),        32'(e.c0));
    endtask

    // Step enabled with no image until frame_done (mode 0) or ring == r (mode 1).
    task automatic run_until(input int mode, input ring_t r);
        int found;
        found = 0;
        for (int i = 0; i < 3 * FRAME && found == 0; i++) begin
            step(1'b1, 1'b0, IMG_NONE);
            if (mode == 0 && frame_done === 1'b1) found = 1;
            if (mode == 1 && ring_counter === r)  found = 1;
        end
        checks++;
        if (found == 0) begin
            failures++;
            $display("FAIL wait_timeout mode=%0d ring=%0b at %0t", mode, r, $time);
        end
    endtask

    initial begin
        vec_t  tbl[20];
        ring_t ring_lit[20];

        ring_lit = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001,
                     3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010,
                     3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100,
                     3'b000, 3'b000};
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{1'b1, 1'b0, ring_lit[i], (i == 17)};
        end

        reset     = 1'b1;
        enable    = 1'b0;
        img_valid = 1'b0;
        {img_col2, img_col1, img_col0} = '0;
        model_reset();
        #12;
        chk("reset_ring",  32'(ring_counter), 32'd0);
        chk("reset_fd",    32'(frame_done),   32'd0);
        chk("reset_ready", 32'(img_ready),    32'd1);
        chk("reset_cols",  32'({col_2, col_1, col_0}), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Free-running scan with no image.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].en, tbl[i].vld, IMG_NONE);
            chk("t1_ring", 32'(ring_counter), 32'(tbl[i].ring));
            chk("t1_fd",   32'(frame_done),   32'(tbl[i].fd));
        end
        step(1'b0, 1'b0, IMG_NONE);

        // Image loaded while idle is applied on enable.
        step(1'b0, 1'b1, IMG_A);
        chk("t2_ready_low", 32'(img_ready), 32'd0);
        step(1'b1, 1'b0, IMG_NONE);
        chk("t2_col2",  32'(col_2), 32'h41);
        chk("t2_col1",  32'(col_1), 32'h22);
        chk("t2_col0",  32'(col_0), 32'h1C);
        chk("t2_ready", 32'(img_ready), 32'd1);

        // Mid-frame image waits for the frame boundary.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, IMG_NONE);
        step(1'b1, 1'b1, IMG_B);
        chk("t3_ready_low", 32'(img_ready), 32'd0);
        chk("t3_hold_a",    32'(col_2),     32'h41);
        run_until(0, 3'b000);
        chk("t3_fd_still_a", 32'(col_2), 32'h41);
        step(1'b1, 1'b0, IMG_NONE);
        chk("t3_col2_b", 32'(col_2), 32'h7F);
        chk("t3_ready",  32'(img_ready), 32'd1);

        // Transfer on the boundary cycle goes to pending only.
        run_until(0, 3'b000);
        step(1'b1, 1'b1, IMG_C);
        chk("t4_no_bypass", 32'(col_2),     32'h7F);
        chk("t4_ready_low", 32'(img_ready), 32'd0);
        run_until(0, 3'b000);
        step(1'b1, 1'b0, IMG_NONE);
        chk("t4_col2_c", 32'(col_2), 32'h15);
        chk("t4_col0_c", 32'(col_0), 32'h08);

        // Enable dropped in phase 1 SHOW.
        run_until(1, 3'b010);
        step(1'b0, 1'b0, IMG_NONE);
        chk("t5_ring_idle", 32'(ring_counter), 32'd0);
        chk("t5_no_fd",     32'(frame_done),   32'd0);
        step(1'b1, 1'b0, IMG_NONE);
        step(1'b1, 1'b0, IMG_NONE);
        step(1'b1, 1'b0, IMG_NONE);
        chk("t5_restart_ph0", 32'(ring_counter), 32'b001);

        // Asynchronous reset in phase 2 with pending full.
        step(1'b1, 1'b1, IMG_D);
        chk("t6_pending_full", 32'(img_ready), 32'd0);
        run_until(1, 3'b100);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("t6_ring", 32'(ring_counter), 32'd0);
        chk("t6_cols", 32'({col_2, col_1, col_0}), 32'd0);
        chk("t6_ready", 32'(img_ready), 32'd1);
        chk("t6_fd", 32'(frame_done), 32'd0);
        model_reset();
        sb_q.delete();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) step(1'b1, 1'b0, IMG_NONE);
        chk("t6_image_lost", 32'({col_2, col_1, col_0}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
